frame_reader: RTL and testbench

// - Read master for the main memory's read-only port B (20-bit address out, 8-bit data in).
// - Walks a contiguous byte region from base_addr for length bytes and streams bytes out on a

---
 rtl/frame_reader_pkg.sv | 16 +
 rtl/frame_reader_byte_fifo.sv | 63 ++++++
 rtl/frame_reader.sv | 145 ++++++++++++++
 tb/tb_frame_reader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_reader_pkg.sv
// Shared types and default widths for the frame_reader read master.
package frame_reader_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned LEN_W_DEF  = 18;
  localparam int unsigned CKSUM_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/frame_reader_byte_fifo.sv
// Small synchronous first-word-fall-through FIFO used as the output buffer of frame_reader.
module byte_fifo #(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en, rd_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  // A push into a full FIFO is legal when the head is popped in the same cycle.
  always_comb begin
    rd_en = pop_i && !empty_o;
    wr_en = push_i && (!full_o || rd_en);
    wr_d  = wr_en ? ptr_inc(wr_q) : wr_q;
    rd_d  = rd_en ? ptr_inc(rd_q) : rd_q;
    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/frame_reader.sv
// Port-B read master: streams length bytes from base_addr onto a valid/ready interface.
// Optional byte checksum enabled by defining FRAME_READER_CHECKSUM_EN.
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned LEN_W      = LEN_W_DEF,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   length,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0]  px_data,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [CKSUM_W-1:0] checksum
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              issue, start_acc;
  int unsigned       inflight, occupancy;

  byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (mem_rdata),
    .pop_i   (fifo_pop),
    .rdata_o (px_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign px_valid  = !fifo_empty;
  assign fifo_pop  = px_valid && px_ready;
  assign fifo_push = pipe_q[RD_LAT-1];
  assign start_acc = (state_q == IDLE) && start;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_addr  = addr_q;

  // Credit: every outstanding read already owns a FIFO slot, so returned data never overflows.
  always_comb begin
    inflight = 0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight += 32'(pipe_q[i]);
    occupancy = 32'(fifo_count) + inflight;
    issue     = (state_q == RUN) && (occupancy < FIFO_DEPTH);
    pipe_d[0] = issue;
    for (int unsigned i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          len_d = length;
          idx_d = '0;
          if (length == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            addr_d  = base_addr;
          end
        end
      end
      RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_W'(1);
          idx_d  = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && (inflight == 0)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(fifo_full && fifo_push && !fifo_pop));
  end

`ifdef FRAME_READER_CHECKSUM_EN
  logic [CKSUM_W-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (start_acc)     cks_d = '0;
    else if (fifo_pop) cks_d = cks_q + CKSUM_W'(px_data);
  end

  always_ff @(posedge clk) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: RD_LAT=1 RAM model returning the low address byte (or 0xFF in fill mode).
module tb_frame_reader;

  logic        clk = 1'b0;
  logic        rst, start, px_ready;
  logic [19:0] base_addr;
  logic [17:0] length;
  logic        busy, done, px_valid;
  logic [19:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  px_data;
  logic [15:0] checksum;

  int   n_err = 0;
  int   n_chk = 0;
  bit   fill_ff = 1'b0;
`ifdef FRAME_READER_CHECKSUM_EN
  localparam bit CKS_EN = 1'b1;
`else
  localparam bit CKS_EN = 1'b0;
`endif

  logic [7:0] got_q[$];
  int         done_cnt, done_k, first_k, last_k, valid_cnt;
  logic       busy_k1;
  logic [19:0] addr0;

  frame_reader #(
    .ADDR_W     (20),
    .DATA_W     (8),
    .LEN_W      (18),
    .RD_LAT     (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .px_data   (px_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= fill_ff ? 8'hFF : mem_addr[7:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one start, then watch the stream for up to max_cyc cycles; k counts cycles after the start edge.
  task automatic run(input logic [19:0] b, input logic [17:0] l, input int pct, input int max_cyc);
    logic       stalled;
    logic [7:0] held;
    got_q.delete();
    done_cnt = 0; done_k = -1; first_k = -1; last_k = -1; valid_cnt = 0;
    stalled = 1'b0; held = '0; busy_k1 = 1'b0;
    @(negedge clk);
    base_addr = b; length = l; start = 1'b1;
    addr0 = mem_addr;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) busy_k1 = busy;
      if (stalled) begin
        chk("stall_valid", 32'(px_valid), 32'd1);
        chk("stall_data", 32'(px_data), 32'(held));
        stalled = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      px_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      if (px_valid) begin
        valid_cnt++;
        if (first_k < 0) first_k = k;
        if (px_ready) begin
          got_q.push_back(px_data);
          last_k = k;
        end else begin
          stalled = 1'b1;
          held    = px_data;
        end
      end
      if (done_k >= 0 && k >= done_k + 2) break;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; px_ready = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(px_valid), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_cks", 32'(checksum), 32'd0);
    rst = 1'b0;

    // Basic run: 0x10..0x13 back-to-back at full rate
    run(20'h00010, 18'd4, 100, 40);
    chk("t1_busy_k1", 32'(busy_k1), 32'd1);
    chk("t1_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("t1_byte%0d", i), 32'(got_q[i]), 32'h10 + 32'(i));
    chk("t1_first_lat", 32'(first_k), 32'd3);
    chk("t1_b2b", 32'(last_k - first_k), 32'd3);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_after", 32'(done_k > last_k), 32'd1);
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_addr_end", 32'(mem_addr), 32'h00014);
    chk("t1_cks", 32'(checksum), CKS_EN ? 32'h0046 : 32'h0);

    // Zero length: done only, no stream, address untouched
    run(20'h00777, 18'd0, 100, 10);
    chk("len0_done_cnt", 32'(done_cnt), 32'd1);
    chk("len0_done_time", 32'(done_k >= 1 && done_k <= 2), 32'd1);
    chk("len0_valid", 32'(valid_cnt), 32'd0);
    chk("len0_addr", 32'(mem_addr), 32'(addr0));
    chk("len0_busy_end", 32'(busy), 32'd0);

    // Address wrap at top of port-B space
    run(20'hFFFFE, 18'd4, 100, 40);
    chk("wrap_count", 32'(got_q.size()), 32'd4);
    chk("wrap_b0", 32'(got_q[0]), 32'hFE);
    chk("wrap_b1", 32'(got_q[1]), 32'hFF);
    chk("wrap_b2", 32'(got_q[2]), 32'h00);
    chk("wrap_b3", 32'(got_q[3]), 32'h01);
    chk("wrap_addr_end", 32'(mem_addr), 32'h00002);
    chk("wrap_done_cnt", 32'(done_cnt), 32'd1);
    chk("wrap_cks", 32'(checksum), CKS_EN ? 32'h01FE : 32'h0);

    // Random backpressure, 30% ready duty
    run(20'h00020, 18'd16, 30, 600);
    chk("bp_count", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("bp_byte%0d", i), 32'(got_q[i]), 32'h20 + 32'(i));
    chk("bp_done_cnt", 32'(done_cnt), 32'd1);
    chk("bp_cks", 32'(checksum), CKS_EN ? 32'h0278 : 32'h0);

    // 300 x 0xFF: checksum wraps to 0x2AD4 and holds after done
    fill_ff = 1'b1;
    run(20'h00000, 18'd300, 100, 400);
    fill_ff = 1'b0;
    chk("fill_count", 32'(got_q.size()), 32'd300);
    chk("fill_first", 32'(got_q[0]), 32'hFF);
    chk("fill_last", 32'(got_q[299]), 32'hFF);
    chk("fill_span", 32'(last_k - first_k), 32'd299);
    chk("fill_done_cnt", 32'(done_cnt), 32'd1);
    chk("fill_cks", 32'(checksum), CKS_EN ? 32'h2AD4 : 32'h0);
    repeat (5) @(negedge clk);
    chk("fill_cks_hold", 32'(checksum), CKS_EN ? 32'h2AD4 : 32'h0);

    // Reset at the fifth byte of a 32-byte run
    @(negedge clk);
    base_addr = 20'h00100; length = 18'd32; start = 1'b1; px_ready = 1'b1;
    valid_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) done_cnt++;
      if (px_valid && px_ready) valid_cnt++;
      if (valid_cnt == 5) break;
    end
    chk("mid_reached5", 32'(valid_cnt), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_valid", 32'(px_valid), 32'd0);
    chk("mid_addr", 32'(mem_addr), 32'd0);
    chk("mid_cks", 32'(checksum), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (px_valid) valid_cnt++;
    end
    chk("mid_no_done", 32'(done_cnt), 32'd0);
    chk("mid_no_stale", 32'(valid_cnt), 32'd5);

    run(20'h00040, 18'd2, 100, 30);
    chk("post_count", 32'(got_q.size()), 32'd2);
    chk("post_b0", 32'(got_q[0]), 32'h40);
    chk("post_b1", 32'(got_q[1]), 32'h41);
    chk("post_done_cnt", 32'(done_cnt), 32'd1);
    chk("post_cks", 32'(checksum), CKS_EN ? 32'h0081 : 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
